// File: rtl/stress_test_pkg.sv
// Shared definitions for the stress-test checker: FSM encoding, LFSR taps
// and the error-counter ceiling.
package stress_test_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_SEED = 2'd1;
   localparam state_t ST_RUN  = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

   // Maximal-length Fibonacci taps: x^16+x^15+x^13+x^4+1 and x^32+x^22+x^2+x+1.
   localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_D008;
   localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/stress_test_lfsr.sv
// Left-shifting Fibonacci LFSR producing the expected data sequence.
// Seeding already shifts once; an all-zero seed is replaced by 1.
module stress_test_lfsr
   import stress_test_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             set_seed,
   input  logic             generate_rnd,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] rnd
);

   localparam logic [31:0]      TAPS_FULL = (WIDTH == 32) ? LFSR_TAPS_32 : LFSR_TAPS_16;
   localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] LFSR_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] state_q;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction

   // NOTE: no reset here on purpose; the checker always seeds before it
   // reads the output, so a reset would only cost routing.
   always_ff @(posedge clk) begin
      if (set_seed) begin
         state_q <= (seed == '0) ? LFSR_ONE : step(seed);
      end else if (generate_rnd) begin
         state_q <= step(state_q);
      end
   end

   assign rnd = state_q;

endmodule

// File: rtl/stress_test_checker.sv
// Checks a received word stream against an LFSR reference, counting words
// and mismatches and capturing the first mismatch.
module stress_test_checker
   import stress_test_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] seed,
   input  logic [31:0]      num_words,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [31:0]      word_count,
   output logic [15:0]      err_count,
   output logic             err_flag,
   output logic [31:0]      first_err_idx,
   output logic [WIDTH-1:0] first_err_exp,
   output logic [WIDTH-1:0] first_err_data
);

   state_t           state;
   logic [31:0]      num_words_q;
   logic [WIDTH-1:0] lfsr_out;
   logic             start_ok;
   logic             handshake;
   logic             mismatch;
   logic             last_word;
   logic [31:0]      wc_next;

   assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign in_ready  = (state == ST_RUN);
   assign busy      = (state == ST_SEED) || (state == ST_RUN);
   assign done      = (state == ST_DONE);
   assign handshake = in_valid && in_ready;
   assign mismatch  = handshake && (in_data != lfsr_out);
   assign wc_next   = word_count + 32'd1;
   // A zero word limit means unbounded; the count then simply wraps.
   assign last_word = handshake && (num_words_q != 32'd0) && (wc_next == num_words_q);

   stress_test_lfsr #(.WIDTH(WIDTH)) u_lfsr (
      .clk          (clk),
      .set_seed     (start_ok),
      .generate_rnd (handshake),
      .seed         (seed),
      .rnd          (lfsr_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         num_words_q    <= '0;
         word_count     <= '0;
         err_count      <= '0;
         err_flag       <= 1'b0;
         first_err_idx  <= '0;
         first_err_exp  <= '0;
         first_err_data <= '0;
      end else if (start_ok) begin
         state          <= ST_SEED;
         num_words_q    <= num_words;
         word_count     <= '0;
         err_count      <= '0;
         err_flag       <= 1'b0;
         first_err_idx  <= '0;
         first_err_exp  <= '0;
         first_err_data <= '0;
      end else if (state == ST_SEED) begin
         state <= ST_RUN;
      end else if (state == ST_RUN) begin
         if (handshake) begin
            word_count <= wc_next;
         end
         if (mismatch) begin
            err_flag <= 1'b1;
            if (err_count != ERR_COUNT_MAX) begin
               err_count <= err_count + 16'd1;
            end
            if (!err_flag) begin
               first_err_idx  <= word_count;
               first_err_exp  <= lfsr_out;
               first_err_data <= in_data;
            end
         end
         if (stop || last_word) begin
            state <= ST_DONE;
         end
      end
   end

endmodule

// File: tb/tb_stress_test_checker.sv
// Directed bench for stress_test_checker (WIDTH=16) with an independent LFSR
// model and a scoreboard of per-word expected counters.
module tb_stress_test_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] seed_i = '0;
   logic [31:0] num_words_i = '0;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready, busy, done, err_flag;
   logic [31:0] word_count, first_err_idx;
   logic [15:0] err_count, first_err_exp, first_err_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] wc;
      logic [15:0] ec;
      logic        flag;
   } exp_t;

   exp_t sb[$];

   logic [15:0] m_lfsr;
   logic [31:0] m_wc, m_fidx;
   logic [15:0] m_ec, m_fexp, m_fdata;
   logic        m_flag;

   stress_test_checker #(.WIDTH(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .stop           (stop),
      .seed           (seed_i),
      .num_words      (num_words_i),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .busy           (busy),
      .done           (done),
      .word_count     (word_count),
      .err_count      (err_count),
      .err_flag       (err_flag),
      .first_err_idx  (first_err_idx),
      .first_err_exp  (first_err_exp),
      .first_err_data (first_err_data)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
   endfunction

   task automatic model_word(input logic [15:0] d);
      if (d !== m_lfsr) begin
         if (!m_flag) begin
            m_fidx  = m_wc;
            m_fexp  = m_lfsr;
            m_fdata = d;
         end
         m_flag = 1'b1;
         if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
      end
      m_wc   = m_wc + 32'd1;
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_in_ready"}, in_ready, 0);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_done"}, done, 0);
      check({pfx, "_word_count"}, word_count, 0);
      check({pfx, "_err_count"}, err_count, 0);
      check({pfx, "_err_flag"}, err_flag, 0);
      check({pfx, "_first_err_idx"}, first_err_idx, 0);
      check({pfx, "_first_err_exp"}, first_err_exp, 0);
      check({pfx, "_first_err_data"}, first_err_data, 0);
   endtask

   // Pulses start and walks through SEED into RUN; the model reseeds itself.
   task automatic do_start(input logic [15:0] s, input logic [31:0] n);
      @(posedge clk); #1;
      start = 1'b1;
      seed_i = s;
      num_words_i = n;
      @(posedge clk); #1;
      start = 1'b0;
      check("seed_busy", busy, 1);
      check("seed_in_ready", in_ready, 0);
      m_lfsr = (s == 16'h0) ? 16'h0001 : lfsr_next(s);
      m_wc = '0; m_ec = '0; m_flag = 1'b0;
      m_fidx = '0; m_fexp = '0; m_fdata = '0;
      @(posedge clk); #1;
      check("run_in_ready", in_ready, 1);
   endtask

   task automatic send_word(input logic [15:0] d, input logic stp);
      exp_t e;
      check("hs_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data = d;
      stop = stp;
      model_word(d);
      sb.push_back('{wc: m_wc, ec: m_ec, flag: m_flag});
      @(posedge clk); #1;
      in_valid = 1'b0;
      stop = 1'b0;
      e = sb.pop_front();
      check("word_count", word_count, e.wc);
      check("err_count", {16'h0, err_count}, {16'h0, e.ec});
      check("err_flag", err_flag, e.flag);
   endtask

   task automatic check_first_err(input string pfx);
      check({pfx, "_first_err_idx"}, first_err_idx, m_fidx);
      check({pfx, "_first_err_exp"}, first_err_exp, m_fexp);
      check({pfx, "_first_err_data"}, first_err_data, m_fdata);
   endtask

   initial begin
      #3;
      check_reset_outputs("reset");
      #9;
      rst_n = 1'b1;

      // stop while idle has no effect
      @(posedge clk); #1;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      check("idle_stop_done", done, 0);
      check("idle_stop_busy", busy, 0);

      // Clean bounded run of four words
      do_start(16'h0001, 32'd4);
      send_word(16'h0002, 1'b0);
      send_word(16'h0004, 1'b0);
      send_word(16'h0008, 1'b0);
      send_word(16'h0011, 1'b0);
      check("b4_done", done, 1);
      check("b4_in_ready", in_ready, 0);
      check("b4_busy", busy, 0);

      // Same run with a corrupted third word
      do_start(16'h0001, 32'd4);
      send_word(16'h0002, 1'b0);
      send_word(16'h0004, 1'b0);
      send_word(16'hDEAD, 1'b0);
      send_word(16'h0011, 1'b0);
      check("bad3_done", done, 1);
      check_first_err("bad3");
      check("bad3_idx_const", first_err_idx, 32'd2);
      check("bad3_exp_const", {16'h0, first_err_exp}, 32'h0008);

      // Zero seed maps to a first word of 1
      do_start(16'h0000, 32'd1);
      send_word(16'h0001, 1'b0);
      check("seed0_good_done", done, 1);
      do_start(16'h0000, 32'd1);
      send_word(16'h0000, 1'b0);
      check("seed0_bad_done", done, 1);
      check_first_err("seed0_bad");

      // Asynchronous reset mid-run, then a fresh run checks from the start
      do_start(16'h0001, 32'd0);
      send_word(16'h0002, 1'b0);
      send_word(16'hBEEF, 1'b0);
      start = 1'b1;
      seed_i = 16'hFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      check("run_start_ignored_ready", in_ready, 1);
      send_word(16'h0008, 1'b0);
      check_first_err("prereset");
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_start(16'h0001, 32'd2);
      send_word(16'h0002, 1'b0);
      send_word(16'h0004, 1'b0);
      check("post_reset_done", done, 1);

      // Random in_valid gaps; stop coincides with the final handshake
      do_start(16'h1234, 32'd0);
      for (int i = 0; i < 30; i++) begin
         if (i == 29) begin
            send_word(m_lfsr, 1'b1);
         end else if ($urandom_range(0, 1) == 1) begin
            send_word(m_lfsr, 1'b0);
         end else begin
            in_data = 16'($urandom);
            @(posedge clk); #1;
         end
      end
      check("rnd_stop_done", done, 1);
      check("rnd_stop_in_ready", in_ready, 0);
      in_valid = 1'b1;
      in_data = 16'h5555;
      stop = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      stop = 1'b0;
      check("done_hold_word_count", word_count, m_wc);
      check("done_hold_err_count", {16'h0, err_count}, {16'h0, m_ec});
      check("done_hold_in_ready", in_ready, 0);
      check("done_hold_done", done, 1);

      // Unbounded run of wrong words saturates the error counter
      do_start(16'hACE1, 32'd0);
      for (int i = 0; i < 70000; i++) begin
         in_valid = 1'b1;
         in_data = ~m_lfsr;
         stop = (i == 69999);
         model_word(~m_lfsr);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      stop = 1'b0;
      check("sat_word_count", word_count, 32'd70000);
      check("sat_err_count", {16'h0, err_count}, 32'h0000_FFFF);
      check("sat_model_err_count", {16'h0, err_count}, {16'h0, m_ec});
      check("sat_done", done, 1);
      check("sat_err_flag", err_flag, 1);
      check_first_err("sat");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
